logic_unit_arbiter: RTL
=======================

Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters: requester 0 is the ALU issue path, requester 1 is the address/mask path.
- Uses round-robin arbitration with valid/ready handshakes on both request and response sides.
- The result is registered, giving 1-cycle latency, with one result in flight.
- Full throughput of 1 op/cycle when responses are consumed immediately.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of grant counters (used only with LOGIC_ARB_STATS_EN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_op  input  2  op code: 00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_ready  output  1  requester 0 op accepted this cycle when high with valid
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- rsp0_valid  output  1  result for requester 0 available
- rsp0_y  output  WIDTH  result for requester 0
- rsp0_ready  input  1  requester 0 consumes result
- rsp1_valid, rsp1_y, rsp1_ready  same as requester 0, for requester 1
- gnt0_cnt  output  CNT_W  accepted-op count, requester 0 (macro only)
- gnt1_cnt  output  CNT_W  accepted-op count, requester 1 (macro only)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=0, last_gnt=1 (requester 0 wins the first tie).
  - rsp0_valid=rsp1_valid=0, result register=0, rsp0_y=rsp1_y=0.
  - Any in-flight result is discarded. Reset release is synchronised by the instantiator.
- States:
  - IDLE: no result held.
  - BUSY: result register valid, owned by `owner`.
- Grant (combinational):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_gnt.
  - Neither valid: no grant.
- can_accept = (state==IDLE) || (state==BUSY && rsp_fire), where rsp_fire = rsp{owner}_valid && rsp{owner}_ready.
- req_i_ready = grant_i && can_accept. A non-granted requester sees ready=0.
- Accept (valid && ready, cycle N):
  - Granted operands and op are muxed into logic_core.
  - Result captured into the result register at the N edge; owner<=i, last_gnt<=i, state<=BUSY.
  - rsp_i_valid=1 in cycle N+1 (latency 1).
- rsp_i_valid = (state==BUSY && owner==i).
- rsp_i_y = the result register when rsp_i_valid, else 0.
- Response held stable until consumed. While unconsumed, no new accept; both req_ready=0.
- rsp_fire with no accept in the same cycle: BUSY -> IDLE.
- rsp_fire with a simultaneous accept: stay BUSY with new owner/result (back-to-back, no bubble).
- last_gnt and owner update only on accept, never on a mere grant.
- Requesters must hold valid/op/operands until ready. Dropping valid early is ignored (no accept, no state change).
- Arithmetic: purely bitwise per bit. NOR = ~(a|b). No carries, no flags.
- Combinational path rsp_ready -> req_ready is intentional. Callers must not loop req_ready back into rsp_ready.

Optional Feature:
- Macro LOGIC_ARB_STATS_EN.
- Defined:
  - gnt0_cnt/gnt1_cnt ports exist, reset to 0.
  - Each increments by 1 on its requester's accept.
  - Wraps modulo 2^CNT_W silently.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package logic_arb_pkg (included header of localparams):
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11
  - state encoding ST_IDLE=1'b0, ST_BUSY=1'b1
  - default WIDTH=32
- One sub-module, logic_core: combinational, inputs a, b, op; output y.
  - Built from per-bit gate instances in a generate loop plus a 4:1 op mux.
  - Instantiated once inside the arbiter.

Test Plan:
- Reset mid-op: accept req0 OR a=32'h0000_FF00 b=32'h0000_00FF, assert rst next cycle -> rsp0_valid=0, rsp0_y=0 immediately (async); after release first tie grants req0.
- Single requester: req0 AND a=32'hF0F0_F0F0 b=32'hFFFF_0000, rsp0_ready=1 -> req0_ready=1 cycle N; rsp0_valid=1, rsp0_y=32'hF0F0_0000 at N+1.
- Tie, round-robin: both valid continuously, both rsp_ready=1, req1 XOR a=32'hAAAA_AAAA b=32'hFFFF_FFFF -> grants 0,1,0,1; rsp1_y=32'h5555_5555; one result per cycle, no bubbles.
- Backpressure: req1 NOR a=0 b=0, rsp1_ready=0 for 3 cycles -> rsp1_y=32'hFFFF_FFFF held stable; req0_ready=req1_ready=0 throughout; accepts resume the cycle rsp1_ready=1.
- Early drop: req0_valid pulses 1 cycle while BUSY and unconsumed -> no accept, owner/last_gnt unchanged.
- With LOGIC_ARB_STATS_EN: 5 accepts req0, 3 accepts req1 -> gnt0_cnt=5, gnt1_cnt=3; CNT_W=2 with 5 accepts -> gnt0_cnt=1.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// Shared op and state encodings for the logic unit arbiter.
// Imported by logic_core and logic_unit_arbiter.
package logic_arb_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_core.sv
// logic_core: combinational bitwise unit, y = a OP b per bit.
// Ports: a_i, b_i [WIDTH], op_i [2] in; y_o [WIDTH] out.
module logic_core
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_or;
  logic [WIDTH-1:0] y_xor;
  logic [WIDTH-1:0] y_nor;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and u_and (y_and[i], a_i[i], b_i[i]);
    or  u_or  (y_or[i],  a_i[i], b_i[i]);
    xor u_xor (y_xor[i], a_i[i], b_i[i]);
    nor u_nor (y_nor[i], a_i[i], b_i[i]);
  end

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = y_and;
      OP_OR:   y_o = y_or;
      OP_XOR:  y_o = y_xor;
      OP_NOR:  y_o = y_nor;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_core between two requesters,
// registered result (1-cycle latency), one result in flight.
// Ports: clk, rst (async high); req{0,1}_valid/op/a/b in, req{0,1}_ready
// out; rsp{0,1}_valid/y out, rsp{0,1}_ready in.
// LOGIC_ARB_STATS_EN adds gnt0_cnt/gnt1_cnt accepted-op counters.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef LOGIC_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_y,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_y,
  input  logic             rsp1_ready
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
`endif
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             gnt0, gnt1;
  logic             rsp_fire;
  logic             can_acc;
  logic             acc0, acc1, acc;
  logic [1:0]       core_op;
  logic [WIDTH-1:0] core_a, core_b, core_y;

  // On a tie the requester that did not win last time goes next.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_q);

  assign rsp0_valid = (state_q == ST_BUSY) && !owner_q;
  assign rsp1_valid = (state_q == ST_BUSY) && owner_q;
  assign rsp0_y     = rsp0_valid ? res_q : '0;
  assign rsp1_y     = rsp1_valid ? res_q : '0;

  assign rsp_fire = (rsp0_valid && rsp0_ready) ||
                    (rsp1_valid && rsp1_ready);
  assign can_acc  = (state_q == ST_IDLE) || rsp_fire;

  assign req0_ready = gnt0 && can_acc;
  assign req1_ready = gnt1 && can_acc;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign acc        = acc0 || acc1;

  assign core_op = gnt1 ? req1_op : req0_op;
  assign core_a  = gnt1 ? req1_a  : req0_a;
  assign core_b  = gnt1 ? req1_b  : req0_b;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .a_i  (core_a),
    .b_i  (core_b),
    .op_i (core_op),
    .y_o  (core_y)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    res_d   = res_q;
    if (acc) begin
      state_d = ST_BUSY;
      owner_d = acc1;
      last_d  = acc1;
      res_d   = core_y;
    end else if (rsp_fire) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      res_q   <= res_d;
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (acc0) gnt0_cnt <= gnt0_cnt + 1'b1;
      if (acc1) gnt1_cnt <= gnt1_cnt + 1'b1;
    end
  end
`endif

endmodule
